// File: rtl/clock_step_controller.sv
// Run/halt/single-step sequencer producing a one-cycle CPU clock enable
// from clk divided by one of four selectable periods.
module clock_step_controller #(
  parameter int unsigned DIV0          = 3000000,
  parameter int unsigned DIV1          = 300000,
  parameter int unsigned DIV2          = 3000,
  parameter int unsigned DIV3          = 1,
  parameter bit          START_RUNNING = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_btn,
  input  logic        step_btn,
  input  logic        halt_req,
  input  logic [1:0]  rate_sel,
  output logic        cpu_ce,
  output logic        running,
  output logic [15:0] ce_count
);

  localparam int unsigned MAX_AB  = (DIV0 > DIV1) ? DIV0 : DIV1;
  localparam int unsigned MAX_CD  = (DIV2 > DIV3) ? DIV2 : DIV3;
  localparam int unsigned MAX_DIV = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CW      = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

  localparam logic [CW-1:0] LAST0 = CW'(DIV0 - 1);
  localparam logic [CW-1:0] LAST1 = CW'(DIV1 - 1);
  localparam logic [CW-1:0] LAST2 = CW'(DIV2 - 1);
  localparam logic [CW-1:0] LAST3 = CW'(DIV3 - 1);

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_t;

  // Terminal count value for a given rate selection.
  function automatic logic [CW-1:0] sel_last(input logic [1:0] sel);
    logic [CW-1:0] last;
    case (sel)
      2'd0:    last = LAST0;
      2'd1:    last = LAST1;
      2'd2:    last = LAST2;
      2'd3:    last = LAST3;
      default: last = LAST0;
    endcase
    return last;
  endfunction

  state_t        state_r, next_state_s;
  logic          run_prev_r, step_prev_r;
  logic          latch_pend_r;
  logic [CW-1:0] count_r, count_next_s;
  logic [CW-1:0] active_last_r, active_last_next_s;
  logic          cpu_ce_r, cpu_ce_next_s;
  logic          running_r;
  logic [15:0]   ce_count_r;
  logic          run_evt_s, step_evt_s, term_s;

  assign run_evt_s  = run_btn & ~run_prev_r;
  assign step_evt_s = step_btn & ~step_prev_r;
  assign term_s     = (count_r == active_last_r);

  // Next-state, divider and clock-enable decode.
  always_comb begin
    next_state_s       = state_r;
    count_next_s       = '0;
    active_last_next_s = active_last_r;
    cpu_ce_next_s      = 1'b0;

    case (state_r)
      S_HALT: begin
        if (run_evt_s && !halt_req) begin
          next_state_s = S_RUN;
        end else if (step_evt_s) begin
          next_state_s = S_STEP;
        end else begin
          next_state_s = S_HALT;
        end
      end
      S_STEP: begin
        next_state_s = S_HALT;
      end
      S_RUN: begin
        if (halt_req || run_evt_s) begin
          next_state_s = S_HALT;
        end else begin
          next_state_s = S_RUN;
        end
      end
      default: begin
        next_state_s = S_HALT;
      end
    endcase

    // The period is only re-sampled at a period boundary, never mid-period.
    if (next_state_s == S_RUN) begin
      if (state_r != S_RUN || term_s) begin
        count_next_s = '0;
      end else begin
        count_next_s = count_r + CW'(1);
      end
      if (state_r != S_RUN || term_s || latch_pend_r) begin
        active_last_next_s = sel_last(rate_sel);
      end else begin
        active_last_next_s = active_last_r;
      end
    end else begin
      count_next_s       = '0;
      active_last_next_s = active_last_r;
    end

    if ((next_state_s == S_RUN && state_r == S_RUN && term_s) || next_state_s == S_STEP) begin
      cpu_ce_next_s = 1'b1;
    end else begin
      cpu_ce_next_s = 1'b0;
    end
  end

  // State, divider and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= START_RUNNING ? S_RUN : S_HALT;
      run_prev_r    <= 1'b0;
      step_prev_r   <= 1'b0;
      latch_pend_r  <= START_RUNNING;
      count_r       <= '0;
      active_last_r <= LAST0;
      cpu_ce_r      <= 1'b0;
      running_r     <= START_RUNNING;
      ce_count_r    <= 16'd0;
    end else begin
      state_r       <= next_state_s;
      run_prev_r    <= run_btn;
      step_prev_r   <= step_btn;
      latch_pend_r  <= 1'b0;
      count_r       <= count_next_s;
      active_last_r <= active_last_next_s;
      cpu_ce_r      <= cpu_ce_next_s;
      running_r     <= (next_state_s == S_RUN);
      if (cpu_ce_next_s) begin
        ce_count_r <= ce_count_r + 16'd1;
      end else begin
        ce_count_r <= ce_count_r;
      end
    end
  end

  assign cpu_ce   = cpu_ce_r;
  assign running  = running_r;
  assign ce_count = ce_count_r;

endmodule
